// File: rtl/board_vga_renderer_pkg.sv
// Shared snake board definitions: cell codes, board size, RGB332 palette and the
// cell-code to colour mapping used by the VGA renderer.
package board_vga_renderer_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned HEIGHT = 16;

  typedef enum logic [3:0] {
    EMPTY = 4'h0,
    RIGHT = 4'h1,
    UP    = 4'h2,
    LEFT  = 4'h4,
    DOWN  = 4'h8,
    APPLE = 4'hF
  } cell_e;

  localparam logic [7:0] COL_BG    = 8'h00;
  localparam logic [7:0] COL_SNAKE = 8'h1C;
  localparam logic [7:0] COL_APPLE = 8'hE0;
  localparam logic [7:0] COL_BAD   = 8'hE3;
  localparam logic [7:0] COL_GRID  = 8'h49;

  // Unknown codes map to magenta so RAM corruption is visible on screen.
  function automatic logic [7:0] cell_colour(input logic [3:0] code, input logic grid);
    logic [7:0] col;
    case (code)
      EMPTY:                 col = grid ? COL_GRID : COL_BG;
      RIGHT, UP, LEFT, DOWN: col = COL_SNAKE;
      APPLE:                 col = COL_APPLE;
      default:               col = COL_BAD;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/board_vga_renderer_vga_timing.sv
// VGA timing core: pixel-enable divider, h/v scan counters, raw active-low syncs,
// visible flag, line/frame wrap strobes and the vblank-aligned frame_tick.
module vga_timing
  import board_vga_renderer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SW    = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SW    = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pix_en_o,
  output logic hs_o,
  output logic vs_o,
  output logic vis_o,
  output logic h_wrap_o,
  output logic v_wrap_o,
  output logic frame_tick_o
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_last, v_last;

  always_comb begin
    pix_en_o = (div_q == DW'(CLK_DIV - 1));
    h_last   = (h_q == HW'(H_TOT - 1));
    v_last   = (v_q == VW'(V_TOT - 1));
    div_d    = pix_en_o ? '0 : div_q + 1'b1;
    h_d      = h_q;
    v_d      = v_q;
    if (pix_en_o) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) begin
        v_d = v_last ? '0 : v_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  always_comb begin
    hs_o         = !((h_q >= HW'(H_VIS + H_FP)) && (h_q < HW'(H_VIS + H_FP + H_SW)));
    vs_o         = !((v_q >= VW'(V_VIS + V_FP)) && (v_q < VW'(V_VIS + V_FP + V_SW)));
    vis_o        = (h_q < HW'(H_VIS)) && (v_q < VW'(V_VIS));
    h_wrap_o     = pix_en_o && h_last;
    v_wrap_o     = pix_en_o && h_last && v_last;
    frame_tick_o = pix_en_o && h_last && (v_q == VW'(V_VIS - 1));
  end

endmodule

// File: rtl/board_vga_renderer.sv
// Snake board VGA renderer: scans the 32x16 board RAM read port and drives 640x480
// RGB332 VGA with a fixed 2-pixel-tick pipeline. Define GRID_LINES_EN for grid lines.
module board_vga_renderer
  import board_vga_renderer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SW    = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SW    = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned CELL_W  = 20,
  parameter int unsigned CELL_H  = 30
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] vram_x,
  output logic [3:0] vram_y,
  output logic       vram_rd,
  input  logic [3:0] vram_out,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [7:0] vga_rgb,
  output logic       frame_tick
);

  localparam int unsigned SXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int unsigned SYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  logic pix_en, hs, vs, vis, h_wrap, v_wrap;

  vga_timing #(
    .CLK_DIV(CLK_DIV),
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SW   (H_SW),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SW   (V_SW),
    .V_BP   (V_BP)
  ) u_timing (
    .clk_i       (clk),
    .rst_i       (rst),
    .pix_en_o    (pix_en),
    .hs_o        (hs),
    .vs_o        (vs),
    .vis_o       (vis),
    .h_wrap_o    (h_wrap),
    .v_wrap_o    (v_wrap),
    .frame_tick_o(frame_tick)
  );

  logic [SXW-1:0] sx_q, sx_d;
  logic [SYW-1:0] sy_q, sy_d;
  logic [4:0]     cx_q, cx_d;
  logic [3:0]     cy_q, cy_d;

  // Cell index tracks the scan position by counting within the cell, avoiding dividers.
  always_comb begin
    sx_d = sx_q;
    cx_d = cx_q;
    sy_d = sy_q;
    cy_d = cy_q;
    if (pix_en) begin
      if (h_wrap) begin
        sx_d = '0;
        cx_d = '0;
      end else if (sx_q == SXW'(CELL_W - 1)) begin
        sx_d = '0;
        cx_d = cx_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
      end
      if (v_wrap) begin
        sy_d = '0;
        cy_d = '0;
      end else if (h_wrap) begin
        if (sy_q == SYW'(CELL_H - 1)) begin
          sy_d = '0;
          cy_d = cy_q + 1'b1;
        end else begin
          sy_d = sy_q + 1'b1;
        end
      end
    end
  end

  logic vis1_q, hs1_q, vs1_q, grid_px;

`ifdef GRID_LINES_EN
  logic grid1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grid1_q <= 1'b0;
    end else if (pix_en) begin
      grid1_q <= (sx_q == '0) || (sy_q == '0);
    end
  end

  always_comb grid_px = grid1_q;
`else
  always_comb grid_px = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx_q      <= '0;
      sy_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      vram_x    <= '0;
      vram_y    <= '0;
      vram_rd   <= 1'b0;
      vis1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_rgb   <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      if (pix_en) begin
        vram_x    <= cx_q;
        vram_y    <= cy_q;
        vram_rd   <= vis;
        vis1_q    <= vis;
        hs1_q     <= hs;
        vs1_q     <= vs;
        // Syncs travel with the colour so all pins share the same latency.
        vga_hsync <= hs1_q;
        vga_vsync <= vs1_q;
        vga_rgb   <= vis1_q ? cell_colour(vram_out, grid_px) : COL_BG;
      end
    end
  end

endmodule

// File: tb/tb_board_vga_renderer.sv
// Self-checking bench for board_vga_renderer on a reduced raster (2x2-pixel cells)
// with a behavioural board RAM and a pin-level scoreboard.
module tb_board_vga_renderer;

  localparam int HV  = 64;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VV  = 32;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int CW  = 2;
  localparam int CH  = 2;
  localparam int HT  = HV + HFP + HSW + HBP;
  localparam int VT  = VV + VFP + VSW + VBP;
  localparam int NV  = 12;

  typedef struct {
    int         h;
    int         v;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } pin_t;

  typedef struct {
    int         cx;
    int         cy;
    logic [3:0] code;
    logic [7:0] rgb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] vram_x;
  logic [3:0] vram_y;
  logic       vram_rd;
  logic [3:0] vram_out;
  logic       vga_hsync;
  logic       vga_vsync;
  logic [7:0] vga_rgb;
  logic       frame_tick;

  board_vga_renderer #(
    .CLK_DIV(2),
    .H_VIS  (HV),
    .H_FP   (HFP),
    .H_SW   (HSW),
    .H_BP   (HBP),
    .V_VIS  (VV),
    .V_FP   (VFP),
    .V_SW   (VSW),
    .V_BP   (VBP),
    .CELL_W (CW),
    .CELL_H (CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vram_x    (vram_x),
    .vram_y    (vram_y),
    .vram_rd   (vram_rd),
    .vram_out  (vram_out),
    .vga_hsync (vga_hsync),
    .vga_vsync (vga_vsync),
    .vga_rgb   (vga_rgb),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [3:0] ram [0:15][0:31];
  logic [7:0] cap [0:VV-1][0:HV-1];
  pin_t       sb[$];
  vec_t       vecs [NV];
  logic [7:0] first_exp;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         e        = 0;
  int         hs_fall_e, vs_fall_e, ft_e;
  logic       hs_prev, vs_prev;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0h, expected %0h", nm, e, act, exp);
    end
  endtask

  function automatic logic exp_hs(input int h);
    return !((h >= HV + HFP) && (h < HV + HFP + HSW));
  endfunction

  function automatic logic exp_vs(input int v);
    return !((v >= VV + VFP) && (v < VV + VFP + VSW));
  endfunction

  function automatic logic [7:0] model_rgb(input int h, input int v);
    logic [3:0] c;
    if (h >= HV || v >= VV) return 8'h00;
    c = ram[v / CH][h / CW];
    case (c)
      4'h0: begin
`ifdef GRID_LINES_EN
        if ((h % CW == 0) || (v % CH == 0)) return 8'h49;
`endif
        return 8'h00;
      end
      4'h1, 4'h2, 4'h4, 4'h8: return 8'h1C;
      4'hF:                   return 8'hE0;
      default:                return 8'hE3;
    endcase
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_vram_x"}, vram_x, 0);
    check({tag, "_vram_y"}, vram_y, 0);
    check({tag, "_vram_rd"}, vram_rd, 0);
    check({tag, "_hsync"}, vga_hsync, 1);
    check({tag, "_vsync"}, vga_vsync, 1);
    check({tag, "_rgb"}, vga_rgb, 0);
    check({tag, "_frame_tick"}, frame_tick, 0);
  endtask

  // Called at a negedge just as reset is released; the next posedge is edge 1.
  task automatic restart();
    e = 0;
    sb.delete();
    sb.push_back('{-1, -1, 1'b1, 1'b1, 8'h00});
    hs_fall_e = 0;
    vs_fall_e = 0;
    ft_e      = 0;
    hs_prev   = 1'b1;
    vs_prev   = 1'b1;
  endtask

  // Pixel p is latched into stage 1 at edge 2p+2 and reaches the pins at edge 2p+4.
  task automatic step();
    int   p, h, v;
    logic vis, ft_exp;
    pin_t exp_pin;
    @(posedge clk);
    #1;
    e++;
    if (vram_rd) vram_out = ram[vram_y][vram_x];
    ft_exp = (e % 2 == 1) && ((((e - 1) / 2) % (HT * VT)) == VV * HT - 1);
    check("frame_tick", frame_tick, ft_exp);
    if (frame_tick) begin
      if (ft_e > 0) check("frame_period", e - ft_e, 2 * HT * VT);
      ft_e = e;
    end
    if (e % 2 == 0) begin
      p   = (e - 2) / 2;
      h   = p % HT;
      v   = (p / HT) % VT;
      vis = (h < HV) && (v < VV);
      check("vram_rd", vram_rd, vis);
      if (vis) begin
        check("vram_x", vram_x, h / CW);
        check("vram_y", vram_y, v / CH);
      end
      sb.push_back('{h, v, exp_hs(h), exp_vs(v), model_rgb(h, v)});
      if (sb.size() > 1) begin
        exp_pin = sb.pop_front();
        check("hsync", vga_hsync, exp_pin.hs);
        check("vsync", vga_vsync, exp_pin.vs);
        check("rgb", vga_rgb, exp_pin.rgb);
        if (exp_pin.h >= 0 && exp_pin.h < HV && exp_pin.v >= 0 && exp_pin.v < VV)
          cap[exp_pin.v][exp_pin.h] = vga_rgb;
      end
    end
    if (hs_prev && !vga_hsync) begin
      if (hs_fall_e > 0) check("line_period", e - hs_fall_e, 2 * HT);
      hs_fall_e = e;
    end
    if (!hs_prev && vga_hsync && hs_fall_e > 0) check("hsync_width", e - hs_fall_e, 2 * HSW);
    if (vs_prev && !vga_vsync) begin
      if (vs_fall_e > 0) check("vsync_period", e - vs_fall_e, 2 * HT * VT);
      vs_fall_e = e;
    end
    if (!vs_prev && vga_vsync && vs_fall_e > 0) check("vsync_width", e - vs_fall_e, 2 * VSW * HT);
    hs_prev = vga_hsync;
    vs_prev = vga_vsync;
  endtask

  initial begin
    vecs[0]  = '{0, 9, 4'h1, 8'h1C};
    vecs[1]  = '{1, 9, 4'h0, 8'h00};
    vecs[2]  = '{0, 8, 4'h0, 8'h00};
    vecs[3]  = '{0, 10, 4'h0, 8'h00};
    vecs[4]  = '{31, 15, 4'hF, 8'hE0};
    vecs[5]  = '{5, 5, 4'h3, 8'hE3};
    vecs[6]  = '{1, 0, 4'h2, 8'h1C};
    vecs[7]  = '{2, 0, 4'h4, 8'h1C};
    vecs[8]  = '{3, 0, 4'h8, 8'h1C};
    vecs[9]  = '{7, 7, 4'h9, 8'hE3};
    vecs[10] = '{20, 12, 4'h7, 8'hE3};
    vecs[11] = '{10, 3, 4'h0, 8'h00};
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 32; x++) ram[y][x] = 4'h0;
    for (int i = 0; i < NV; i++) ram[vecs[i].cy][vecs[i].cx] = vecs[i].code;

    vram_out = 4'h0;
    rst      = 1'b1;
    #17;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;
    restart();

    while (e < 2 * HT * VT + 10) step();

    for (int i = 0; i < NV; i++) begin
      first_exp = vecs[i].rgb;
`ifdef GRID_LINES_EN
      if (vecs[i].code == 4'h0) first_exp = 8'h49;
`endif
      check($sformatf("cell_first(%0d,%0d)", vecs[i].cx, vecs[i].cy),
            cap[vecs[i].cy * CH][vecs[i].cx * CW], first_exp);
      check($sformatf("cell_last(%0d,%0d)", vecs[i].cx, vecs[i].cy),
            cap[vecs[i].cy * CH + CH - 1][vecs[i].cx * CW + CW - 1], vecs[i].rgb);
    end

    // Stop with the apple cell (31,15) in flight, then reset asynchronously mid-cycle.
    while (e < 2 * (HT * VT + 31 * HT + 63) + 2) step();
    check("pre_rst_vram_x", vram_x, 31);
    check("pre_rst_rgb", vga_rgb, 8'hE0);
    #2;
    rst = 1'b1;
    #1;
    check_reset("mid");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    restart();

    for (int n = 0; n < 1000 && hs_fall_e == 0; n++) step();
    check("first_hsync_fall", hs_fall_e, 2 * (HV + HFP) + 4);

    while (e < 4 * HT * VT + 20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
